poly_mod_sub: RTL and testbench
===============================

# poly_mod_sub

Streaming modular subtractor for ML-KEM (FIPS 203) polynomial arithmetic: accepts coefficient pairs (a, b) over a valid/ready handshake and emits (a − b) mod Q, one registered beat per accepted pair. Tracks the coefficient index within a 256-coefficient polynomial and flags the final coefficient. Sits beside the combinational modular adder in the poly-arith datapath as its inverse operation, feeding NTT/accumulate stages that need a flow-controlled, single-cycle-latency stream.

## Interface
- `N_COEFFS`, default 256: coefficients per polynomial; must be a power of two.
- `clk`  in  1  system clock, all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid_i`  in  1  input beat valid.
- `in_ready_o`  out  1  block can accept a beat this cycle.
- `op1_i`  in  coeff_t (12)  minuend a, in [0, Q−1].
- `op2_i`  in  coeff_t (12)  subtrahend b, in [0, Q−1].
- `out_valid_o`  out  1  result beat valid.
- `out_ready_i`  in  1  downstream accepts result.
- `result_o`  out  coeff_t (12)  (a − b) mod Q.
- `idx_o`  out  $clog2(N_COEFFS)  coefficient index of the current output beat.
- `last_o`  out  1  high with the output beat whose `idx_o` = N_COEFFS−1.
- `err_o`  out  1  sticky range error; present only with `POLY_MOD_SUB_RANGE_CHK_EN`.

## Operation
- Arithmetic: 13-bit difference d = {0,a} − {0,b}. If d[12] (negative), result = d + Q, else result = d; truncated to 12 bits. Result always in [0, Q−1] for in-range inputs.
- Input accept: beat taken when `in_valid_i && in_ready_o`.
- `in_ready_o = !out_valid_o || out_ready_i` (single output register, full-throughput pass-through under continuous ready).
- On accept: `result_o`, `idx_o`, `last_o` loaded from computed value and input counter; `out_valid_o` set.
- On output handshake with no simultaneous accept: `out_valid_o` cleared; `result_o`/`idx_o`/`last_o` hold.
- Simultaneous output handshake and input accept: register overwritten with new beat, `out_valid_o` stays 1.
- Input counter: increments on each accept, wraps N_COEFFS−1 → 0 without stall; next polynomial begins immediately.
- Output held stable while `out_valid_o && !out_ready_i`; no beat dropped or duplicated.
- `in_valid_i` low: no state change except output drain.

## Timing
- Latency: 1 cycle from accept to `out_valid_o`.
- Throughput: 1 beat/cycle with `out_ready_i` held high.
- Reset values: `out_valid_o`=0, `result_o`=0, `idx_o`=0, `last_o`=0, `err_o`=0, input counter 0; `in_ready_o`=1 (combinational from `out_valid_o`=0).
- Reset mid-polynomial: pending output discarded, counter to 0; next accepted beat is index 0.
- `rst` dominates any concurrent handshake in the same cycle.

## Configuration
- `POLY_MOD_SUB_RANGE_CHK_EN` defined: `err_o` port exists; set on accept of any beat with `op1_i` ≥ Q or `op2_i` ≥ Q; stays set until `rst`. Result for such beats is computed by the same rule, not saturated.
- Undefined: no `err_o` port, no check logic; out-of-range inputs produce unspecified but deterministic results.

## Structure
- `poly_arith_pkg`: `coeff_t`, `Q` (3329), `N_COEFFS_DEF` (256), index type `coeff_idx_t`.
- Sub-module `mod_sub`: purely combinational (op1_i, op2_i → result_o) core; `poly_mod_sub` wraps it with handshake register and counter.

## Test plan
- a=20, b=10 → 10; a=10, b=20 → 3319; a=0, b=3328 → 1; a=3328, b=0 → 3328; a=b=1234 → 0; each one cycle after accept.
- 256 back-to-back beats, `out_ready_i`=1 → 256 outputs, `idx_o` 0..255, `last_o` only on 255; beat 257 shows `idx_o`=0, `last_o`=0.
- Random `out_ready_i` stalls (≈50%) with continuous input → no loss/duplication, `result_o` stable while stalled, order matches golden queue.
- Assert `rst` after 100 accepted beats with an output pending → `out_valid_o`=0 next cycle; following beat outputs `idx_o`=0.
- With `POLY_MOD_SUB_RANGE_CHK_EN`: accept a=3329, b=0 → `err_o`=1 next cycle and remains 1 over subsequent valid beats until `rst`.
- 1000 random in-range pairs vs. golden model (a−b+Q)%Q → zero mismatches.

Source files
------------

// File: rtl/poly_mod_sub_pkg.sv
// Shared types and constants for ML-KEM polynomial arithmetic (Q = 3329, 12-bit coefficients).
// Optional range checking in poly_mod_sub is enabled by defining POLY_MOD_SUB_RANGE_CHK_EN.
package poly_arith_pkg;

  localparam int Q            = 3329;
  localparam int COEFF_W      = 12;
  localparam int N_COEFFS_DEF = 256;

  typedef logic [COEFF_W-1:0]              coeff_t;
  typedef logic [$clog2(N_COEFFS_DEF)-1:0] coeff_idx_t;

  localparam coeff_t Q_C = coeff_t'(Q);

  function automatic logic coeff_in_range(input coeff_t c);
    return c < Q_C;
  endfunction

endpackage

// File: rtl/poly_mod_sub_if.sv
// Handshake bundle for poly_mod_sub: input pair stream in, reduced result stream out.
// err_o exists only when POLY_MOD_SUB_RANGE_CHK_EN is defined.
interface poly_mod_sub_if
  import poly_arith_pkg::*;
#(
  parameter int N_COEFFS = N_COEFFS_DEF
) ();

  localparam int IDX_W = $clog2(N_COEFFS);

  logic             in_valid_i;
  logic             in_ready_o;
  coeff_t           op1_i;
  coeff_t           op2_i;
  logic             out_valid_o;
  logic             out_ready_i;
  coeff_t           result_o;
  logic [IDX_W-1:0] idx_o;
  logic             last_o;
`ifdef POLY_MOD_SUB_RANGE_CHK_EN
  logic             err_o;
`endif

  modport master (
    output in_valid_i, op1_i, op2_i, out_ready_i,
    input  in_ready_o, out_valid_o, result_o, idx_o, last_o
`ifdef POLY_MOD_SUB_RANGE_CHK_EN
    , err_o
`endif
  );

  modport slave (
    input  in_valid_i, op1_i, op2_i, out_ready_i,
    output in_ready_o, out_valid_o, result_o, idx_o, last_o
`ifdef POLY_MOD_SUB_RANGE_CHK_EN
    , err_o
`endif
  );

endinterface

// File: rtl/poly_mod_sub_mod_sub.sv
// Combinational (a - b) mod Q for a, b in [0, Q-1]; a borrow out of the 13-bit
// difference means the result wrapped negative and needs Q added back.
module mod_sub
  import poly_arith_pkg::*;
(
  input  coeff_t op1_i,
  input  coeff_t op2_i,
  output coeff_t result_o
);

  logic [COEFF_W:0] w_diff;
  coeff_t           w_corr;

  assign w_diff   = {1'b0, op1_i} - {1'b0, op2_i};
  // Modulo-4096 addition of Q recovers d + Q since that sum always fits in 12 bits.
  assign w_corr   = w_diff[COEFF_W] ? Q_C : '0;
  assign result_o = w_diff[COEFF_W-1:0] + w_corr;

endmodule

// File: rtl/poly_mod_sub.sv
// Streaming modular subtractor: one registered (a - b) mod Q beat per accepted pair, 1-cycle latency.
// Single output register with pass-through ready; optional sticky err_o under POLY_MOD_SUB_RANGE_CHK_EN.
module poly_mod_sub
  import poly_arith_pkg::*;
#(
  parameter int N_COEFFS = N_COEFFS_DEF
) (
  input logic           clk,
  input logic           rst,
  poly_mod_sub_if.slave bus
);

  localparam int IDX_W = $clog2(N_COEFFS);

  logic             w_accept;
  coeff_t           w_result;
  logic             r_out_valid;
  coeff_t           r_result;
  logic [IDX_W-1:0] r_idx;
  logic             r_last;
  logic [IDX_W-1:0] r_cnt;

  mod_sub u_mod_sub (
    .op1_i    (bus.op1_i),
    .op2_i    (bus.op2_i),
    .result_o (w_result)
  );

  assign bus.in_ready_o = !r_out_valid || bus.out_ready_i;
  assign w_accept       = bus.in_valid_i && bus.in_ready_o;

  // Counter wraps naturally because N_COEFFS is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_idx       <= '0;
      r_last      <= 1'b0;
      r_cnt       <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_result    <= w_result;
      r_idx       <= r_cnt;
      r_last      <= (r_cnt == IDX_W'(N_COEFFS - 1));
      r_cnt       <= r_cnt + IDX_W'(1);
    end else if (r_out_valid && bus.out_ready_i) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.out_valid_o = r_out_valid;
  assign bus.result_o    = r_result;
  assign bus.idx_o       = r_idx;
  assign bus.last_o      = r_last;

`ifdef POLY_MOD_SUB_RANGE_CHK_EN
  logic r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_accept && !(coeff_in_range(bus.op1_i) && coeff_in_range(bus.op2_i))) begin
      r_err <= 1'b1;
    end
  end

  assign bus.err_o = r_err;
`endif

endmodule

// File: tb/tb_poly_mod_sub.sv
// Self-checking bench for poly_mod_sub: directed vectors, index wrap, random stalls,
// mid-stream reset, random pairs, and the optional range-error flag.
module tb_poly_mod_sub;
  import poly_arith_pkg::*;

  localparam int N = 256;

  typedef struct {
    int res;
    int idx;
    bit last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_acc    = 0;
  exp_t exp_q[$];

  poly_mod_sub_if #(.N_COEFFS(N)) bus ();

  poly_mod_sub #(.N_COEFFS(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic int ref_sub(input int a, input int b);
    return (a - b + Q) % Q;
  endfunction

  function automatic exp_t ref_beat(input int a, input int b, input int k);
    exp_t e;
    e.res  = ref_sub(a, b);
    e.idx  = k % N;
    e.last = ((k % N) == N - 1);
    return e;
  endfunction

  task automatic do_reset();
    rst            = 1'b1;
    bus.in_valid_i = 1'b0;
    bus.out_ready_i = 1'b1;
    bus.op1_i      = '0;
    bus.op2_i      = '0;
    repeat (2) @(posedge clk);
    #1;
    rst   = 1'b0;
    n_acc = 0;
  endtask

  task automatic test_reset();
    do_reset();
    bus.out_ready_i = 1'b0;
    #1;
    n_checks++;
    if (bus.out_valid_o !== 1'b0 || bus.result_o !== 12'd0 || bus.idx_o !== 8'd0 || bus.last_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got vld=%b res=%0d idx=%0d last=%b, want 0/0/0/0",
               bus.out_valid_o, bus.result_o, bus.idx_o, bus.last_o);
    end
    n_checks++;
    if (bus.in_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b want 1", bus.in_ready_o);
    end
`ifdef POLY_MOD_SUB_RANGE_CHK_EN
    n_checks++;
    if (bus.err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_err: got %b want 0", bus.err_o);
    end
`endif
    bus.out_ready_i = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_vectors();
    int va[5] = '{20, 10, 0, 3328, 1234};
    int vb[5] = '{10, 20, 3328, 0, 1234};
    int vr[5] = '{10, 3319, 1, 3328, 0};
    for (int i = 0; i < 5; i++) begin
      bus.in_valid_i = 1'b1;
      bus.op1_i      = 12'(va[i]);
      bus.op2_i      = 12'(vb[i]);
      @(posedge clk);
      #1;
      bus.in_valid_i = 1'b0;
      n_checks++;
      if (bus.out_valid_o !== 1'b1 || bus.result_o !== 12'(vr[i]) || bus.idx_o !== 8'(i)) begin
        n_fail++;
        $display("FAIL vector_%0d: got vld=%b res=%0d idx=%0d, want 1/%0d/%0d",
                 i, bus.out_valid_o, bus.result_o, bus.idx_o, vr[i], i);
      end
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.out_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL vector_drain: out_valid got %b want 0", bus.out_valid_o);
    end
  endtask

  task automatic test_back_to_back();
    int   a, b;
    exp_t e;
    do_reset();
    for (int i = 0; i <= N; i++) begin
      a = $urandom_range(0, Q - 1);
      b = $urandom_range(0, Q - 1);
      bus.in_valid_i = 1'b1;
      bus.op1_i      = 12'(a);
      bus.op2_i      = 12'(b);
      e = ref_beat(a, b, i);
      @(posedge clk);
      #1;
      n_checks++;
      if (bus.out_valid_o !== 1'b1 || bus.result_o !== 12'(e.res) ||
          bus.idx_o !== 8'(e.idx) || bus.last_o !== e.last) begin
        n_fail++;
        $display("FAIL b2b_beat_%0d: got vld=%b res=%0d idx=%0d last=%b, want 1/%0d/%0d/%b",
                 i, bus.out_valid_o, bus.result_o, bus.idx_o, bus.last_o, e.res, e.idx, e.last);
      end
    end
    bus.in_valid_i = 1'b0;
    n_acc = N + 1;
  endtask

  task automatic test_stall();
    bit     hold = 1'b0;
    bit     rdy, acc;
    int     a, b;
    coeff_t h_res;
    logic [7:0] h_idx;
    logic   h_last;
    exp_t   e;
    do_reset();
    exp_q.delete();
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (hold) begin
        n_checks++;
        if (bus.out_valid_o !== 1'b1 || bus.result_o !== h_res || bus.idx_o !== h_idx || bus.last_o !== h_last) begin
          n_fail++;
          $display("FAIL stall_hold_%0d: got vld=%b res=%0d idx=%0d, want 1/%0d/%0d",
                   cyc, bus.out_valid_o, bus.result_o, bus.idx_o, h_res, h_idx);
        end
      end
      rdy = 1'($urandom_range(0, 1));
      a   = $urandom_range(0, Q - 1);
      b   = $urandom_range(0, Q - 1);
      if (bus.out_valid_o === 1'b1 && rdy) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL stall_extra_beat_%0d: got res=%0d, want no beat", cyc, bus.result_o);
        end else begin
          e = exp_q.pop_front();
          if (bus.result_o !== 12'(e.res) || bus.idx_o !== 8'(e.idx) || bus.last_o !== e.last) begin
            n_fail++;
            $display("FAIL stall_order_%0d: got res=%0d idx=%0d, want %0d/%0d",
                     cyc, bus.result_o, bus.idx_o, e.res, e.idx);
          end
        end
      end
      hold   = (bus.out_valid_o === 1'b1) && !rdy;
      h_res  = bus.result_o;
      h_idx  = bus.idx_o;
      h_last = bus.last_o;
      acc    = (bus.out_valid_o !== 1'b1) || rdy;
      if (acc) begin
        exp_q.push_back(ref_beat(a, b, n_acc));
        n_acc++;
      end
      bus.in_valid_i  = 1'b1;
      bus.op1_i       = 12'(a);
      bus.op2_i       = 12'(b);
      bus.out_ready_i = rdy;
      #1;
      n_checks++;
      if (bus.in_ready_o !== acc) begin
        n_fail++;
        $display("FAIL stall_in_ready_%0d: got %b want %b", cyc, bus.in_ready_o, acc);
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (bus.out_valid_o === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL drain_extra_beat: got res=%0d, want no beat", bus.result_o);
        end else begin
          e = exp_q.pop_front();
          if (bus.result_o !== 12'(e.res) || bus.idx_o !== 8'(e.idx)) begin
            n_fail++;
            $display("FAIL drain_order: got res=%0d idx=%0d, want %0d/%0d",
                     bus.result_o, bus.idx_o, e.res, e.idx);
          end
        end
      end
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (exp_q.size() != 0 || bus.out_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_lost_beats: got %0d missing, vld=%b, want 0 missing, vld=0",
               exp_q.size(), bus.out_valid_o);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 100; i++) begin
      bus.in_valid_i = 1'b1;
      bus.op1_i      = 12'($urandom_range(0, Q - 1));
      bus.op2_i      = 12'($urandom_range(0, Q - 1));
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (bus.out_valid_o !== 1'b1 || bus.idx_o !== 8'd99) begin
      n_fail++;
      $display("FAIL rstmid_pending: got vld=%b idx=%0d, want 1/99", bus.out_valid_o, bus.idx_o);
    end
    bus.out_ready_i = 1'b1;
    bus.op1_i       = 12'd100;
    bus.op2_i       = 12'd1;
    rst             = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_checks++;
    if (bus.out_valid_o !== 1'b0 || bus.idx_o !== 8'd0 || bus.result_o !== 12'd0) begin
      n_fail++;
      $display("FAIL rstmid_discard: got vld=%b idx=%0d res=%0d, want 0/0/0",
               bus.out_valid_o, bus.idx_o, bus.result_o);
    end
    bus.op1_i = 12'd7;
    bus.op2_i = 12'd2;
    @(posedge clk);
    #1;
    bus.in_valid_i = 1'b0;
    n_checks++;
    if (bus.out_valid_o !== 1'b1 || bus.idx_o !== 8'd0 || bus.result_o !== 12'd5) begin
      n_fail++;
      $display("FAIL rstmid_restart: got vld=%b idx=%0d res=%0d, want 1/0/5",
               bus.out_valid_o, bus.idx_o, bus.result_o);
    end
    n_acc = 1;
  endtask

  task automatic test_random();
    int   a, b;
    int   bad = 0;
    exp_t e;
    for (int i = 0; i < 1000; i++) begin
      a = $urandom_range(0, Q - 1);
      b = $urandom_range(0, Q - 1);
      bus.in_valid_i = 1'b1;
      bus.op1_i      = 12'(a);
      bus.op2_i      = 12'(b);
      e = ref_beat(a, b, n_acc);
      n_acc++;
      @(posedge clk);
      #1;
      n_checks++;
      if (bus.out_valid_o !== 1'b1 || bus.result_o !== 12'(e.res) || bus.idx_o !== 8'(e.idx)) begin
        n_fail++;
        bad++;
        if (bad < 10)
          $display("FAIL random_%0d: a=%0d b=%0d got res=%0d idx=%0d, want %0d/%0d",
                   i, a, b, bus.result_o, bus.idx_o, e.res, e.idx);
      end
    end
    bus.in_valid_i = 1'b0;
  endtask

`ifdef POLY_MOD_SUB_RANGE_CHK_EN
  task automatic test_range_chk();
    do_reset();
    bus.in_valid_i = 1'b1;
    bus.op1_i      = 12'd3329;
    bus.op2_i      = 12'd0;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.err_o !== 1'b1 || bus.result_o !== 12'd3329) begin
      n_fail++;
      $display("FAIL range_set: got err=%b res=%0d, want 1/3329", bus.err_o, bus.result_o);
    end
    for (int i = 0; i < 5; i++) begin
      bus.op1_i = 12'($urandom_range(0, Q - 1));
      bus.op2_i = 12'($urandom_range(0, Q - 1));
      @(posedge clk);
      #1;
      n_checks++;
      if (bus.err_o !== 1'b1) begin
        n_fail++;
        $display("FAIL range_sticky_%0d: got err=%b want 1", i, bus.err_o);
      end
    end
    do_reset();
    n_checks++;
    if (bus.err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL range_clear: got err=%b want 0", bus.err_o);
    end
  endtask
`endif

  initial begin
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b1;
    bus.op1_i       = '0;
    bus.op2_i       = '0;
    test_reset();
    test_vectors();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_random();
`ifdef POLY_MOD_SUB_RANGE_CHK_EN
    test_range_chk();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
